// File: rtl/alu_seq.sv
// Registered 16-op ALU with NZCV flags and valid/ready handshakes on both sides.
// Multiply runs as a WIDTH-cycle shift-add; every other op completes on its accept edge.
module alu_seq #(
    parameter int WIDTH     = 8,
    parameter int ROT_AMT   = 1,
    parameter int SIGNED_LT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
    logic [WIDTH-1:0]     mplier_reg, mplier_next;
    logic [WIDTH-1:0]     x_reg, x_next;
    logic                 n_reg, n_next, z_reg, z_next, c_reg, c_next, v_reg, v_next;
    logic                 out_valid_reg, out_valid_next;

    logic                 accept;
    logic [WIDTH:0]       sum_ext, diff_ext;
    logic [WIDTH-1:0]     neg_a, neg_b, msb_only;
    logic [2*WIDTH-1:0]   ror_a_wide, ror_b_wide;
    logic                 lt;
    logic [WIDTH-1:0]     alu_x;
    logic                 alu_c, alu_v;
    logic [2*WIDTH-1:0]   mul_sum;

    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready) && !reset;
    assign accept   = in_valid && in_ready;

    assign sum_ext    = {1'b0, a} + {1'b0, b};
    assign diff_ext   = {1'b0, a} - {1'b0, b};
    assign neg_a      = '0 - a;
    assign neg_b      = '0 - b;
    assign msb_only   = {1'b1, {(WIDTH-1){1'b0}}};
    // Rotating the doubled word keeps ROT_AMT=0 well defined.
    assign ror_a_wide = {a, a} >> ROT_AMT;
    assign ror_b_wide = {b, b} >> ROT_AMT;
    assign lt         = (SIGNED_LT != 0) ? ($signed(a) < $signed(b)) : (a < b);
    assign mul_sum    = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_comb begin
        alu_x = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (select)
            4'h0: alu_x = '0;
            4'h1: alu_x = a;
            4'h2: alu_x = b;
            4'h3: begin alu_x = neg_a; alu_v = (a == msb_only); end
            4'h4: begin alu_x = neg_b; alu_v = (b == msb_only); end
            4'h5: alu_x = ror_a_wide[WIDTH-1:0];
            4'h6: alu_x = ror_b_wide[WIDTH-1:0];
            4'h7: alu_x = {{(WIDTH-1){1'b0}}, lt};
            4'h8: alu_x = a & b;
            4'h9: alu_x = ~a;
            4'hA: alu_x = ~b;
            4'hB: begin
                alu_x = diff_ext[WIDTH-1:0];
                alu_c = diff_ext[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            4'hC: begin
                alu_x = sum_ext[WIDTH-1:0];
                alu_c = sum_ext[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            4'hE: alu_x = a | b;
            4'hF: alu_x = a ^ b;
            default: alu_x = '0;
        endcase
    end

    always_comb begin
        logic             load;
        logic [WIDTH-1:0] load_x;
        logic             load_c, load_v;
        load           = 1'b0;
        load_x         = '0;
        load_c         = 1'b0;
        load_v         = 1'b0;
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        x_next         = x_reg;
        n_next         = n_reg;
        z_next         = z_reg;
        c_next         = c_reg;
        v_next         = v_reg;
        out_valid_next = out_valid_reg && !out_ready;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (select == 4'hD) begin
                        mcand_next  = {{WIDTH{1'b0}}, a};
                        mplier_next = b;
                        acc_next    = '0;
                        cnt_next    = CW'(WIDTH-1);
                        state_next  = MUL;
                    end else begin
                        load   = 1'b1;
                        load_x = alu_x;
                        load_c = alu_c;
                        load_v = alu_v;
                    end
                end
            end
            MUL: begin
                acc_next    = mul_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                if (cnt_reg == '0) begin
                    load       = 1'b1;
                    load_x     = mul_sum[WIDTH-1:0];
                    load_c     = |mul_sum[2*WIDTH-1:WIDTH];
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            x_next         = load_x;
            n_next         = load_x[WIDTH-1];
            z_next         = (load_x == '0);
            c_next         = load_c;
            v_next         = load_v;
            out_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            x_reg         <= '0;
            n_reg         <= 1'b0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            mcand_reg     <= mcand_next;
            mplier_reg    <= mplier_next;
            x_reg         <= x_next;
            n_reg         <= n_next;
            z_reg         <= z_next;
            c_reg         <= c_next;
            v_reg         <= v_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign x         = x_reg;
    assign flag_n    = n_reg;
    assign flag_z    = z_reg;
    assign flag_c    = c_reg;
    assign flag_v    = v_reg;
    assign out_valid = out_valid_reg;
endmodule
